// File: rtl/control_ejecucion_if_pkg.sv
// -----------------------------------------------------------------------------
// control_if_pkg
// Shared definitions for the instruction-fetch execution sequencer:
//   - UART command codes
//   - FSM state encodings (visible on o_estado)
//   - NOP instruction word shared with the IF stage
//   - saturating 32-bit increment used by the cycle counter
// -----------------------------------------------------------------------------
package control_if_pkg;

    // Command bytes accepted in IDLE / DONE
    localparam logic [7:0] CMD_LOAD = 8'h01;
    localparam logic [7:0] CMD_RUN  = 8'h02;
    localparam logic [7:0] CMD_STEP = 8'h03;
    localparam logic [7:0] CMD_STOP = 8'h04;

    // Word count N arrives as two bytes, MSB first
    localparam int unsigned N_WIDTH = 16;

    // NOP instruction, also used by the IF stage
    localparam logic [31:0] NOP_WORD = 32'h0021_0824;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOAD_N_HI  = 3'd1,
        ST_LOAD_N_LO  = 3'd2,
        ST_LOAD_BYTES = 3'd3,
        ST_LOAD_WRITE = 3'd4,
        ST_RUN        = 3'd5,
        ST_STEP       = 3'd6,
        ST_DONE       = 3'd7
    } estado_e;

    // Cycle counter sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/control_ejecucion_if_if.sv
// -----------------------------------------------------------------------------
// control_ejecucion_if_if
// Bundle of the sequencer's UART-side inputs and IF/pipeline-side outputs.
//   master : the sequencer (consumes i_*, drives o_*)
//   slave  : the surrounding system (drives i_*, consumes o_*)
// Signals:
//   i_rx_data / i_rx_done : received UART byte and its one-cycle valid pulse
//   i_halt                : HALT has reached writeback (level)
//   o_enable_mem, o_write_read_mem, o_addr_mem, o_data_mem : program memory port
//   o_control_mux_addr_mem: 1 = memory addressed by loader, 0 = by PC
//   o_enable_contador_PC, o_enable_pipeline : execution enables
//   o_programa_cargado, o_error, o_ciclos, o_estado : status
// -----------------------------------------------------------------------------
interface control_ejecucion_if_if #(
    parameter int CANT_BITS_ADDR      = 11,
    parameter int RAM_WIDTH_PROGRAMA  = 32,
    parameter int CANT_BITS_DATO_UART = 8
);
    logic [CANT_BITS_DATO_UART-1:0] i_rx_data;
    logic                           i_rx_done;
    logic                           i_halt;

    logic                           o_enable_mem;
    logic                           o_write_read_mem;
    logic [CANT_BITS_ADDR-1:0]      o_addr_mem;
    logic [RAM_WIDTH_PROGRAMA-1:0]  o_data_mem;
    logic                           o_control_mux_addr_mem;
    logic                           o_enable_contador_PC;
    logic                           o_enable_pipeline;
    logic                           o_programa_cargado;
    logic                           o_error;
    logic [31:0]                    o_ciclos;
    logic [2:0]                     o_estado;

    modport master (
        input  i_rx_data, i_rx_done, i_halt,
        output o_enable_mem, o_write_read_mem, o_addr_mem, o_data_mem,
               o_control_mux_addr_mem, o_enable_contador_PC, o_enable_pipeline,
               o_programa_cargado, o_error, o_ciclos, o_estado
    );

    modport slave (
        output i_rx_data, i_rx_done, i_halt,
        input  o_enable_mem, o_write_read_mem, o_addr_mem, o_data_mem,
               o_control_mux_addr_mem, o_enable_contador_PC, o_enable_pipeline,
               o_programa_cargado, o_error, o_ciclos, o_estado
    );
endinterface

// File: rtl/control_ejecucion_if_ensamblador.sv
// -----------------------------------------------------------------------------
// ensamblador_palabra
// Big-endian byte-to-word assembler: each shifted byte enters at the LSB end,
// so the first of a group lands in the word's MSB byte.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   clear_i        : restart the byte count (start of a new load)
//   shift_i        : shift byte_i in this cycle
//   byte_i         : incoming byte
//   word_o         : assembled word (complete the cycle after word_ready_o)
//   word_ready_o   : combinational, high while the last byte of a word shifts in
// -----------------------------------------------------------------------------
module ensamblador_palabra #(
    parameter int BYTE_W = 8,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              shift_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_ready_o
);
    localparam int BYTES = WORD_W / BYTE_W;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES - 1);

    logic [WORD_W-1:0] word_q;
    logic [CNT_W-1:0]  cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else if (clear_i) begin
            cnt_q  <= '0;
        end else if (shift_i) begin
            word_q <= {word_q[WORD_W-BYTE_W-1:0], byte_i};
            cnt_q  <= (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign word_o       = word_q;
    assign word_ready_o = shift_i && (cnt_q == LAST);

endmodule

// File: rtl/control_ejecucion_if.sv
// -----------------------------------------------------------------------------
// control_ejecucion_if
// Instruction-fetch sequencer. Decodes UART command bytes, loads program memory
// word by word (LOAD), then runs the pipeline continuously (RUN) or one clock
// at a time (STEP) until HALT or STOP.
// Ports:
//   i_clock      : system clock, rising edge
//   i_soft_reset : asynchronous active-low reset
//   bus          : control_ejecucion_if_if.master (UART in, memory/enables out)
// -----------------------------------------------------------------------------
module control_ejecucion_if
    import control_if_pkg::*;
#(
    parameter int CANT_BITS_ADDR      = 11,
    parameter int RAM_WIDTH_PROGRAMA  = 32,
    parameter int CANT_BITS_DATO_UART = 8
) (
    input  logic                    i_clock,
    input  logic                    i_soft_reset,
    control_ejecucion_if_if.master  bus
);
    // Index must reach N == 2**CANT_BITS_ADDR, hence one extra bit
    localparam int          IDX_W     = CANT_BITS_ADDR + 1;
    localparam int unsigned MAX_WORDS = 2 ** CANT_BITS_ADDR;

    estado_e                 state_q, state_d;
    logic [N_WIDTH-1:0]      n_q, n_d;
    logic [IDX_W-1:0]        index_q, index_d;
    logic                    cargado_q, cargado_d;
    logic                    error_q, error_d;
    logic [31:0]             ciclos_q, ciclos_d;

    logic                    asm_clear, asm_shift, word_ready;
    logic [RAM_WIDTH_PROGRAMA-1:0] word;

    logic [7:0]              rx_byte;
    logic                    rx_done;
    logic [N_WIDTH-1:0]      n_full;
    logic [IDX_W-1:0]        idx_inc;

    assign rx_byte = bus.i_rx_data;
    assign rx_done = bus.i_rx_done;
    assign n_full  = {n_q[N_WIDTH-1:8], rx_byte};
    assign idx_inc = index_q + IDX_W'(1);

    ensamblador_palabra #(
        .BYTE_W (CANT_BITS_DATO_UART),
        .WORD_W (RAM_WIDTH_PROGRAMA)
    ) u_ensamblador (
        .clk          (i_clock),
        .rst_n        (i_soft_reset),
        .clear_i      (asm_clear),
        .shift_i      (asm_shift),
        .byte_i       (rx_byte),
        .word_o       (word),
        .word_ready_o (word_ready)
    );

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge i_clock or negedge i_soft_reset) begin
        if (!i_soft_reset) begin
            state_q   <= ST_IDLE;
            n_q       <= '0;
            index_q   <= '0;
            cargado_q <= 1'b0;
            error_q   <= 1'b0;
            ciclos_q  <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            index_q   <= index_d;
            cargado_q <= cargado_d;
            error_q   <= error_d;
            ciclos_q  <= ciclos_d;
        end
    end

    // ---------------------------------------------------------------- next state
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        index_d   = index_q;
        cargado_d = cargado_q;
        ciclos_d  = ciclos_q;
        error_d   = 1'b0;
        asm_clear = 1'b0;
        asm_shift = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (rx_done) begin
                    case (rx_byte)
                        CMD_LOAD: begin
                            cargado_d = 1'b0;
                            ciclos_d  = '0;
                            index_d   = '0;
                            asm_clear = 1'b1;
                            state_d   = ST_LOAD_N_HI;
                        end
                        CMD_RUN: begin
                            if (cargado_q) state_d = ST_RUN;
                            else           error_d = 1'b1;
                        end
                        CMD_STEP: begin
                            if (cargado_q) state_d = ST_STEP;
                            else           error_d = 1'b1;
                        end
                        CMD_STOP: ;  // nothing running, nothing to stop
                        default:  error_d = 1'b1;
                    endcase
                end
            end

            ST_LOAD_N_HI: begin
                if (rx_done) begin
                    n_d     = {rx_byte, n_q[7:0]};
                    state_d = ST_LOAD_N_LO;
                end
            end

            ST_LOAD_N_LO: begin
                if (rx_done) begin
                    n_d = n_full;
                    if ({16'd0, n_full} > 32'(MAX_WORDS)) begin
                        error_d = 1'b1;
                        state_d = ST_IDLE;
                    end else if (n_full == '0) begin
                        cargado_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d = ST_LOAD_BYTES;
                    end
                end
            end

            ST_LOAD_BYTES: begin
                asm_shift = rx_done;
                if (word_ready) state_d = ST_LOAD_WRITE;
            end

            // Single write cycle; a byte arriving here is dropped
            ST_LOAD_WRITE: begin
                index_d = idx_inc;
                if (N_WIDTH'(idx_inc) == n_q) begin
                    cargado_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_LOAD_BYTES;
                end
            end

            // Only STOP is meaningful while running; other bytes are ignored
            ST_RUN: begin
                ciclos_d = sat_inc(ciclos_q);
                if (bus.i_halt || (rx_done && rx_byte == CMD_STOP))
                    state_d = ST_DONE;
            end

            ST_STEP: begin
                ciclos_d = sat_inc(ciclos_q);
                state_d  = bus.i_halt ? ST_DONE : ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    logic                          en_mem, wr_mem, mux_mem, en_pc, en_pipe;
    logic [CANT_BITS_ADDR-1:0]     addr_mem;
    logic [RAM_WIDTH_PROGRAMA-1:0] data_mem;

    always_comb begin
        en_mem   = 1'b0;
        wr_mem   = 1'b0;
        mux_mem  = 1'b0;
        en_pc    = 1'b0;
        en_pipe  = 1'b0;
        addr_mem = '0;
        data_mem = '0;

        case (state_q)
            ST_LOAD_N_HI, ST_LOAD_N_LO, ST_LOAD_BYTES: mux_mem = 1'b1;
            ST_LOAD_WRITE: begin
                en_mem   = 1'b1;
                wr_mem   = 1'b1;
                mux_mem  = 1'b1;
                addr_mem = index_q[CANT_BITS_ADDR-1:0];
                data_mem = word;
            end
            ST_RUN, ST_STEP: begin
                en_mem  = 1'b1;
                en_pc   = 1'b1;
                en_pipe = 1'b1;
            end
            ST_DONE: en_mem = 1'b1;
            default: ;
        endcase
    end

    assign bus.o_enable_mem           = en_mem;
    assign bus.o_write_read_mem       = wr_mem;
    assign bus.o_addr_mem             = addr_mem;
    assign bus.o_data_mem             = data_mem;
    assign bus.o_control_mux_addr_mem = mux_mem;
    assign bus.o_enable_contador_PC   = en_pc;
    assign bus.o_enable_pipeline      = en_pipe;
    assign bus.o_programa_cargado     = cargado_q;
    assign bus.o_error                = error_q;
    assign bus.o_ciclos               = ciclos_q;
    assign bus.o_estado               = state_q;

endmodule

// File: doc/control_ejecucion_if.md
Name: control_ejecucion_if

Overview:
- Sequencer for the instruction-fetch stage: takes command/data bytes from the UART receiver and drives the IF control inputs.
- Loads program memory word by word, then runs the pipeline continuously or one clock at a time (single step).
- Sits between the UART RX and the top-level IF/pipeline enables; the sole owner of the memory write port and the PC/pipeline enables.

Parameters:
CANT_BITS_ADDR, 11, program memory address width (depth 2**CANT_BITS_ADDR words)
RAM_WIDTH_PROGRAMA, 32, instruction width; must equal 4*CANT_BITS_DATO_UART
CANT_BITS_DATO_UART, 8, UART byte width

Ports:
i_clock  in  1  system clock, rising-edge
i_soft_reset  in  1  asynchronous, active-low reset
i_rx_data  in  8  received UART byte
i_rx_done  in  1  one-cycle pulse, i_rx_data valid
i_halt  in  1  HALT instruction has reached writeback (level)
o_enable_mem  out  1  program memory enable
o_write_read_mem  out  1  1 = write, 0 = read
o_addr_mem  out  CANT_BITS_ADDR  loader write address
o_data_mem  out  RAM_WIDTH_PROGRAMA  loader write data
o_control_mux_addr_mem  out  1  1 = memory addressed by o_addr_mem, 0 = by PC
o_enable_contador_PC  out  1  PC advance enable
o_enable_pipeline  out  1  pipeline register enable
o_programa_cargado  out  1  a valid program is resident
o_error  out  1  one-cycle pulse on a rejected command
o_ciclos  out  32  clocks executed since the last load
o_estado  out  3  current state encoding

Behaviour:
- Reset: all outputs 0, state IDLE, o_programa_cargado 0, o_ciclos 0, word index 0, byte counter 0.
- Commands (accepted only in IDLE or DONE, on i_rx_done): 0x01 LOAD, 0x02 RUN, 0x03 STEP, 0x04 STOP.
- States and encodings: IDLE 0, LOAD_N_HI 1, LOAD_N_LO 2, LOAD_BYTES 3, LOAD_WRITE 4, RUN 5, STEP 6, DONE 7.
- LOAD:
  - Clears o_programa_cargado and o_ciclos, then goes to LOAD_N_HI.
  - Next two bytes give word count N, MSB first (16-bit).
  - If N > 2**CANT_BITS_ADDR: o_error pulse, return to IDLE.
  - If N == 0: set o_programa_cargado, go to IDLE.
  - Otherwise go to LOAD_BYTES.
- LOAD_BYTES:
  - Shifts in bytes big-endian: first byte lands in [31:24].
  - After the 4th byte, go to LOAD_WRITE.
- LOAD_WRITE:
  - Lasts exactly one cycle: o_enable_mem=1, o_write_read_mem=1, o_control_mux_addr_mem=1, o_addr_mem=index, o_data_mem=assembled word.
  - Index increments. If index reaches N, set o_programa_cargado and go to IDLE; else return to LOAD_BYTES.
- During all LOAD_* states: o_control_mux_addr_mem=1, PC and pipeline enables 0. Write strobe appears exactly 1 cycle after the i_rx_done of the 4th byte.
- RUN / STEP with o_programa_cargado=0: o_error pulse, stay in the current state.
- RUN:
  - From the cycle after the command, o_enable_contador_PC = o_enable_pipeline = 1, o_enable_mem=1, o_write_read_mem=0, o_control_mux_addr_mem=0.
  - o_ciclos increments each RUN cycle.
  - When i_halt is sampled high, or STOP (0x04) is received, enables drop on the next cycle and the state goes to DONE.
  - If both occur in the same cycle: one transition to DONE.
  - Any other byte during RUN is ignored, with no o_error.
- STEP:
  - Enables high for exactly one cycle, the cycle after the command.
  - o_ciclos +1.
  - Returns to IDLE, or to DONE if i_halt is high in that cycle.
- DONE:
  - Enables 0, mux on PC, o_enable_mem=1 read.
  - LOAD allowed; RUN/STEP allowed (continue execution).
- Unknown command byte in IDLE/DONE: o_error pulse, state unchanged. STOP in IDLE/DONE: no-op.
- o_ciclos saturates at 0xFFFFFFFF.
- Asynchronous reset mid-operation: immediate return to reset values; a partial load is discarded (o_programa_cargado=0).
- i_rx_done during LOAD_WRITE cannot occur by UART timing; if it does, the byte is dropped.

Decomposition:
- Package control_if_pkg:
  - command codes CMD_LOAD/CMD_RUN/CMD_STEP/CMD_STOP;
  - state encodings;
  - the NOP word constant 32'h00210824 shared with IF.
- One sub-module is natural: ensamblador_palabra (4-byte shift register plus byte counter, outputs a word-ready pulse). Everything else lives in the FSM.

Test Plan:
- Reset then LOAD, N=2, bytes 00 21 08 24 8C 01 00 04 -> writes addr0=0x00210824, addr1=0x8C010004, each strobe 1 cycle after the 4th byte; o_programa_cargado=1; state IDLE.
- LOAD with N=0x0801 (2049) -> o_error 1 cycle, state IDLE, no memory write.
- RUN after load, i_halt asserted 10 cycles later -> enables high 10 cycles then 0, o_ciclos=10, state DONE (7).
- Three STEP commands -> three isolated 1-cycle enable pulses, o_ciclos=3; RUN before any load -> o_error, enables stay 0.
- Reset asserted after 5 bytes of a load -> all outputs 0 immediately; new LOAD N=1 writes addr 0 correctly.
- RUN, then byte 0x03 (ignored) then STOP -> enables stay high through the ignored byte, drop 1 cycle after STOP, state DONE.
